// File: rtl/eq_pkg.sv
// Shared types and constants for the pot sequencer: FSM states, pot count,
// and the fixed sequence-index to A2D-channel map.
package eq_pkg;

    typedef enum logic [1:0] {
        GAP   = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int NUM_POTS = 5;
    localparam int IDX_W    = 3;

    // Index order is LP, B1, B2, HP, VOL; entry is the A2D channel wired to that pot.
    localparam logic [2:0] CH_MAP [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3};

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_POTS - 1)) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/pot_sequencer_if.sv
// A2D SPI master start/complete handshake as seen by the pot sequencer.
interface pot_sequencer_if;
    // strt_cnv is a one-cycle request carrying chnnl; chnnl holds until the
    // matching cnv_cmplt pulse (res valid only in that cycle) or an abort.
    // There is no back-pressure: the A2D master is assumed ready for each start.
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
    modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface

// File: rtl/pot_sequencer_seq_timer.sv
// Loadable counter with a terminal-match flag; counts down by default or up
// when UP is set, so one block serves both the gap and the timeout.
module seq_timer #(
    parameter int             W       = 16,
    parameter bit             UP      = 1'b0,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic         at_term
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = UP ? cnt_q + ONE : cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term = (cnt_q == term_val);

endmodule

// File: rtl/pot_sequencer.sv
// Round-robins the five slide pots through the A2D master and keeps the
// latest 12-bit reading of each in a register for the band-scale stages.
module pot_sequencer
    import eq_pkg::*;
#(
    parameter logic [15:0] GAP_CYCLES     = 16'd1024,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
    parameter bit          INVERT         = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    pot_sequencer_if.master        a2d,
    output logic [11:0]            lp_pot,
    output logic [11:0]            b1_pot,
    output logic [11:0]            b2_pot,
    output logic [11:0]            hp_pot,
    output logic [11:0]            vol_pot,
    output logic                   pots_vld,
    output logic                   cnv_err,
    output state_t                 dbg_state
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                strt_q, strt_d;
    logic [2:0]          chnnl_q, chnnl_d;
    logic [11:0]         pots_q [NUM_POTS];
    logic [11:0]         pots_d [NUM_POTS];
    logic [NUM_POTS-1:0] wr_q, wr_d;
    logic                err_q, err_d;

    logic gap_load, gap_tc;
    logic to_load, to_tc;
    logic cnv_done;

    seq_timer #(.W(16), .UP(1'b0), .RST_VAL(GAP_CYCLES)) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_CYCLES),
        .en       (state_q == GAP),
        .term_val (16'd1),
        .at_term  (gap_tc)
    );

    seq_timer #(.W(16), .UP(1'b1), .RST_VAL(16'd0)) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .load_val (16'd0),
        .en       (state_q == WAIT),
        .term_val (TIMEOUT_CYCLES - 16'd1),
        .at_term  (to_tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        strt_d   = 1'b0;
        chnnl_d  = chnnl_q;
        pots_d   = pots_q;
        wr_d     = wr_q;
        err_d    = err_q;
        gap_load = 1'b0;
        to_load  = 1'b0;
        cnv_done = 1'b0;

        case (state_q)
            GAP: begin
                if (gap_tc) begin
                    state_d = START;
                    strt_d  = 1'b1;
                end
            end
            START: begin
                to_load = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the threshold cycle still counts as a success.
                if (a2d.cnv_cmplt) begin
                    pots_d[idx_q] = INVERT ? ~a2d.res : a2d.res;
                    wr_d[idx_q]   = 1'b1;
                    cnv_done      = 1'b1;
                end else if (to_tc) begin
                    err_d    = 1'b1;
                    cnv_done = 1'b1;
                end
            end
            default: state_d = GAP;
        endcase

        if (cnv_done) begin
            idx_d    = next_idx(idx_q);
            chnnl_d  = CH_MAP[idx_d];
            gap_load = 1'b1;
            state_d  = GAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GAP;
            idx_q   <= '0;
            strt_q  <= 1'b0;
            chnnl_q <= CH_MAP[0];
            pots_q  <= '{default: 12'h000};
            wr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            strt_q  <= strt_d;
            chnnl_q <= chnnl_d;
            pots_q  <= pots_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    assign a2d.strt_cnv = strt_q;
    assign a2d.chnnl    = chnnl_q;
    assign lp_pot       = pots_q[0];
    assign b1_pot       = pots_q[1];
    assign b2_pot       = pots_q[2];
    assign hp_pot       = pots_q[3];
    assign vol_pot      = pots_q[4];
    assign pots_vld     = &wr_q;
    assign cnv_err      = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pot_sequencer.sv
// Directed bench for pot_sequencer: sequencing, per-channel values, timeout,
// completion/timeout race, reset mid-conversion and the inverted variant.
module tb_pot_sequencer;
  import eq_pkg::*;

  localparam int G   = 8;
  localparam int T   = 64;
  localparam int LAT = 20;

  logic clk;
  logic rst;

  pot_sequencer_if a2d();
  pot_sequencer_if a2d_inv();

  logic [11:0] lp_pot, b1_pot, b2_pot, hp_pot, vol_pot;
  logic        pots_vld, cnv_err;
  state_t      dbg_state;

  logic [11:0] inv_lp, inv_b1, inv_b2, inv_hp, inv_vol;
  logic        inv_vld, inv_err;
  state_t      inv_state;

  int n_cmp;
  int n_err;

  logic [2:0] exp_q[$];

  pot_sequencer #(.GAP_CYCLES(16'd8), .TIMEOUT_CYCLES(16'd64), .INVERT(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a2d       (a2d),
    .lp_pot    (lp_pot),
    .b1_pot    (b1_pot),
    .b2_pot    (b2_pot),
    .hp_pot    (hp_pot),
    .vol_pot   (vol_pot),
    .pots_vld  (pots_vld),
    .cnv_err   (cnv_err),
    .dbg_state (dbg_state)
  );

  pot_sequencer #(.GAP_CYCLES(16'd8), .TIMEOUT_CYCLES(16'd64), .INVERT(1'b1)) u_dut_inv (
    .clk       (clk),
    .rst       (rst),
    .a2d       (a2d_inv),
    .lp_pot    (inv_lp),
    .b1_pot    (inv_b1),
    .b2_pot    (inv_b2),
    .hp_pot    (inv_hp),
    .vol_pot   (inv_vol),
    .pots_vld  (inv_vld),
    .cnv_err   (inv_err),
    .dbg_state (inv_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    a2d.cnv_cmplt = 1'b0;
    a2d_inv.cnv_cmplt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [11:0] pot_of(input int idx);
    case (idx)
      0: return lp_pot;
      1: return b1_pot;
      2: return b2_pot;
      3: return hp_pot;
      default: return vol_pot;
    endcase
  endfunction

  // driver tasks
  task automatic wait_strt(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      n++;
      if (a2d.strt_cnv === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL strt_wait: got no strt_cnv within %0d cycles, want one", n);
    end
  endtask

  // Called in the strt_cnv cycle; pulses cnv_cmplt LAT cycles later.
  task automatic complete(input logic [11:0] val, input logic [2:0] ch);
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        n_cmp++;
        if (a2d.strt_cnv !== 1'b0) begin
          n_err++;
          $display("FAIL strt_pulse_len: got %b want 0", a2d.strt_cnv);
        end
      end
    end
    n_cmp++;
    if (a2d.chnnl !== ch) begin
      n_err++;
      $display("FAIL chnnl_stable: got %0d want %0d", a2d.chnnl, ch);
    end
    a2d.cnv_cmplt = 1'b1;
    a2d.res = val;
    @(posedge clk); #1;
    a2d.cnv_cmplt = 1'b0;
    a2d.res = 12'h000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({lp_pot, b1_pot, b2_pot, hp_pot, vol_pot} !== 60'h0) begin
      n_err++;
      $display("FAIL rst_pots: got %h want 0", {lp_pot, b1_pot, b2_pot, hp_pot, vol_pot});
    end
    n_cmp++;
    if ({pots_vld, cnv_err, a2d.strt_cnv} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_flags: got %b want 000", {pots_vld, cnv_err, a2d.strt_cnv});
    end
    n_cmp++;
    if (a2d.chnnl !== 3'd1) begin
      n_err++;
      $display("FAIL rst_chnnl: got %0d want 1", a2d.chnnl);
    end
    n_cmp++;
    if (dbg_state !== GAP) begin
      n_err++;
      $display("FAIL rst_state: got %0d want %0d", dbg_state, GAP);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    int n;
    bit ok;
    logic [2:0] exp_ch;
    do_reset();
    exp_q = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd1};
    for (int i = 0; i < 5; i++) begin
      wait_strt(n, ok);
      n_cmp++;
      if (n !== G) begin
        n_err++;
        $display("FAIL seq_gap[%0d]: got %0d cycles want %0d", i, n, G);
      end
      exp_ch = exp_q.pop_front();
      n_cmp++;
      if (a2d.chnnl !== exp_ch) begin
        n_err++;
        $display("FAIL seq_chnnl[%0d]: got %0d want %0d", i, a2d.chnnl, exp_ch);
      end
      n_cmp++;
      if (pots_vld !== 1'b0) begin
        n_err++;
        $display("FAIL seq_vld_early[%0d]: got %b want 0", i, pots_vld);
      end
      complete(12'hA5A, exp_ch);
      n_cmp++;
      if (pot_of(i) !== 12'hA5A) begin
        n_err++;
        $display("FAIL seq_pot[%0d]: got %h want a5a", i, pot_of(i));
      end
    end
    n_cmp++;
    if (pots_vld !== 1'b1) begin
      n_err++;
      $display("FAIL seq_vld: got %b want 1", pots_vld);
    end
    wait_strt(n, ok);
    exp_ch = exp_q.pop_front();
    n_cmp++;
    if (a2d.chnnl !== exp_ch) begin
      n_err++;
      $display("FAIL seq_wrap: got %0d want %0d", a2d.chnnl, exp_ch);
    end
  endtask

  task automatic test_distinct();
    int n;
    bit ok;
    logic [2:0] ch;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_strt(n, ok);
      ch = a2d.chnnl;
      complete({1'b0, ch + 3'd1, 8'h00}, ch);
    end
    n_cmp++;
    if ({b1_pot, lp_pot, hp_pot, vol_pot, b2_pot} !== {12'h100, 12'h200, 12'h300, 12'h400, 12'h500}) begin
      n_err++;
      $display("FAIL distinct_pots: got b1=%h lp=%h hp=%h vol=%h b2=%h want 100 200 300 400 500",
               b1_pot, lp_pot, hp_pot, vol_pot, b2_pot);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    do_reset();
    wait_strt(n, ok);
    complete(12'h111, 3'd1);
    wait_strt(n, ok);
    complete(12'h222, 3'd0);
    wait_strt(n, ok);
    n_cmp++;
    if (a2d.chnnl !== 3'd4) begin
      n_err++;
      $display("FAIL to_chnnl: got %0d want 4", a2d.chnnl);
    end
    for (int j = 0; j < T; j++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cnv_err !== 1'b0) begin
      n_err++;
      $display("FAIL to_early: got cnv_err=%b want 0 at %0d cycles", cnv_err, T);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({cnv_err, dbg_state} !== {1'b1, GAP}) begin
      n_err++;
      $display("FAIL to_abort: got err=%b state=%0d want err=1 state=%0d", cnv_err, dbg_state, GAP);
    end
    n_cmp++;
    if (b2_pot !== 12'h000) begin
      n_err++;
      $display("FAIL to_b2_kept: got %h want 000", b2_pot);
    end
    wait_strt(n, ok);
    n_cmp++;
    if ({n[7:0], a2d.chnnl} !== {8'(G), 3'd2}) begin
      n_err++;
      $display("FAIL to_next: got gap=%0d ch=%0d want gap=%0d ch=2", n, a2d.chnnl, G);
    end
    complete(12'h333, 3'd2);
    wait_strt(n, ok);
    complete(12'h444, 3'd3);
    n_cmp++;
    if (pots_vld !== 1'b0) begin
      n_err++;
      $display("FAIL to_vld: got %b want 0", pots_vld);
    end
    n_cmp++;
    if ({lp_pot, b1_pot, hp_pot, vol_pot, cnv_err} !== {12'h111, 12'h222, 12'h333, 12'h444, 1'b1}) begin
      n_err++;
      $display("FAIL to_pots: got lp=%h b1=%h hp=%h vol=%h err=%b want 111 222 333 444 1",
               lp_pot, b1_pot, hp_pot, vol_pot, cnv_err);
    end
  endtask

  task automatic test_race();
    int n;
    bit ok;
    do_reset();
    wait_strt(n, ok);
    for (int j = 0; j < T; j++) begin
      @(posedge clk); #1;
    end
    a2d.cnv_cmplt = 1'b1;
    a2d.res = 12'h3C3;
    @(posedge clk); #1;
    a2d.cnv_cmplt = 1'b0;
    n_cmp++;
    if ({lp_pot, cnv_err} !== {12'h3C3, 1'b0}) begin
      n_err++;
      $display("FAIL race: got lp=%h err=%b want lp=3c3 err=0", lp_pot, cnv_err);
    end
    wait_strt(n, ok);
    n_cmp++;
    if (a2d.chnnl !== 3'd0) begin
      n_err++;
      $display("FAIL race_next: got %0d want 0", a2d.chnnl);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int total;
    bit ok;
    do_reset();
    wait_strt(n, ok);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a2d.cnv_cmplt = 1'b1;
    a2d.res = 12'hFFF;
    @(posedge clk); #1;
    a2d.cnv_cmplt = 1'b0;
    total = 1;
    n_cmp++;
    if ({lp_pot, b1_pot, b2_pot, hp_pot, vol_pot} !== 60'h0) begin
      n_err++;
      $display("FAIL rmw_pots: got %h want 0", {lp_pot, b1_pot, b2_pot, hp_pot, vol_pot});
    end
    n_cmp++;
    if ({a2d.chnnl, a2d.strt_cnv, dbg_state} !== {3'd1, 1'b0, GAP}) begin
      n_err++;
      $display("FAIL rmw_ctrl: got ch=%0d strt=%b state=%0d want ch=1 strt=0 state=%0d",
               a2d.chnnl, a2d.strt_cnv, dbg_state, GAP);
    end
    wait_strt(n, ok);
    total += n;
    n_cmp++;
    if (total !== G) begin
      n_err++;
      $display("FAIL rmw_gap: got %0d cycles want %0d", total, G);
    end
  endtask

  task automatic test_invert();
    int n;
    bit ok;
    do_reset();
    a2d_inv.cnv_cmplt = 1'b1;
    a2d_inv.res = 12'h123;
    @(posedge clk); #1;
    a2d_inv.cnv_cmplt = 1'b0;
    n = 1;
    n_cmp++;
    if ({inv_lp, inv_b1, inv_b2, inv_hp, inv_vol} !== 60'h0) begin
      n_err++;
      $display("FAIL inv_spurious: got %h want 0", {inv_lp, inv_b1, inv_b2, inv_hp, inv_vol});
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (a2d_inv.strt_cnv === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if ({ok, n[7:0], a2d_inv.chnnl} !== {1'b1, 8'(G), 3'd1}) begin
      n_err++;
      $display("FAIL inv_strt: got ok=%b gap=%0d ch=%0d want ok=1 gap=%0d ch=1", ok, n, a2d_inv.chnnl, G);
    end
    for (int j = 0; j < LAT; j++) begin
      @(posedge clk); #1;
    end
    a2d_inv.cnv_cmplt = 1'b1;
    a2d_inv.res = 12'h00F;
    @(posedge clk); #1;
    a2d_inv.cnv_cmplt = 1'b0;
    n_cmp++;
    if (inv_lp !== 12'hFF0) begin
      n_err++;
      $display("FAIL inv_lp: got %h want ff0", inv_lp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a2d.cnv_cmplt = 1'b0;
    a2d.res = 12'h000;
    a2d_inv.cnv_cmplt = 1'b0;
    a2d_inv.res = 12'h000;
    test_reset();
    test_sequence();
    test_distinct();
    test_timeout();
    test_race();
    test_reset_mid_wait();
    test_invert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
